// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : led_pattern_ctrl
//  Purpose  : Multi-channel LED pattern controller. A KEY press starts or
//             stops the pattern. SEL picks blink / solid / chase / dim, and
//             can be changed live while a pattern runs. A shared prescaler
//             sets the pattern rate to one tick every DIV clock cycles.
//  Ports    : CLK    in   system clock, rising edge
//             RST_N  in   asynchronous active-low reset
//             KEY    in   start/stop button, synchronised and debounced
//             SEL    in   [1:0] mode: 0 blink, 1 solid, 2 chase, 3 dim
//             LED    out  [N_LED-1:0] registered LED drive, 1 = lit
//             STATE  out  [2:0] registered FSM state code
//             TICK   out  registered pulse, the cycle after the prescaler wraps
//  Params   : N_LED  LED channels, 2..32
//             DIV    clock cycles per pattern tick, 2..65535
//  Revision : 1.0  initial release
// ============================================================================
module led_pattern_ctrl #(
  parameter int N_LED = 4,
  parameter int DIV   = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             KEY,
  input  logic [1:0]       SEL,
  output logic [N_LED-1:0] LED,
  output logic [2:0]       STATE,
  output logic             TICK
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int CNT_W = $clog2(DIV);

  localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] c_cnt_zero = '0;
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  localparam logic [N_LED-1:0] c_led_off  = '0;
  localparam logic [N_LED-1:0] c_led_on   = '1;
  localparam logic [N_LED-1:0] c_led_bit0 = N_LED'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BLINK = 3'd1;
  localparam logic [2:0] S_SOLID = 3'd2;
  localparam logic [2:0] S_CHASE = 3'd3;
  localparam logic [2:0] S_DIM   = 3'd4;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]       r_state;
  logic             r_key_q;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_phase;
  logic [N_LED-1:0] r_led;
  logic             r_tick;

  // --------------------------------------------------------------------------
  // Combinational wires
  // --------------------------------------------------------------------------
  logic             w_press;
  logic [2:0]       w_sel_state;
  logic [2:0]       w_next_state;
  logic             w_change;
  logic             w_active;
  logic             w_wrap;
  logic [CNT_W-1:0] w_cnt_next;
  logic [1:0]       w_phase_inc;
  logic [1:0]       w_phase_next;
  logic [N_LED-1:0] w_led_next;

  // Rising edge of KEY; a held key therefore yields a single press.
  assign w_press = KEY & ~r_key_q;

  // --------------------------------------------------------------------------
  // Process 1: state register (FSM state plus all datapath registers)
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_key_q <= 1'b0;
      r_cnt   <= c_cnt_zero;
      r_phase <= 2'd0;
      r_led   <= c_led_off;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_key_q <= KEY;
      r_cnt   <= w_cnt_next;
      r_phase <= w_phase_next;
      r_led   <= w_led_next;
      r_tick  <= w_wrap;
    end
  end

  // --------------------------------------------------------------------------
  // Process 2: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_sel_state = S_BLINK;
    case (SEL)
      2'd0:    w_sel_state = S_BLINK;
      2'd1:    w_sel_state = S_SOLID;
      2'd2:    w_sel_state = S_CHASE;
      default: w_sel_state = S_DIM;
    endcase
  end

  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE: begin
        w_next_state = w_press ? w_sel_state : S_IDLE;
      end
      S_BLINK, S_SOLID, S_CHASE, S_DIM: begin
        // A press stops the pattern even if SEL moves in the same cycle;
        // otherwise SEL is followed live (equal SEL simply means stay).
        if (w_press) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = w_sel_state;
        end
      end
      default: begin
        // Codes 5..7 cannot be reached; recover to IDLE if ever seen.
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign w_change = (w_next_state != r_state);

  // --------------------------------------------------------------------------
  // Process 3: output / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_active = 1'b0;
    case (r_state)
      S_BLINK, S_SOLID, S_CHASE, S_DIM: w_active = 1'b1;
      default:                          w_active = 1'b0;
    endcase
  end

  // A wrap only counts when the pattern keeps running in the same mode, so
  // a mode switch always restarts the tick period from zero.
  assign w_wrap = w_active && !w_change && (r_cnt == c_cnt_max);

  always_comb begin
    w_cnt_next = c_cnt_zero;
    if (w_change || !w_active) begin
      w_cnt_next = c_cnt_zero;
    end else if (r_cnt == c_cnt_max) begin
      w_cnt_next = c_cnt_zero;
    end else begin
      w_cnt_next = r_cnt + c_cnt_one;
    end
  end

  // Dim phase free-runs; restarting it at every state change guarantees it
  // is zero on DIM entry, where LED is already loaded all-on.
  assign w_phase_inc = r_phase + 2'd1;

  always_comb begin
    w_phase_next = w_phase_inc;
    if (w_change) begin
      w_phase_next = 2'd0;
    end
  end

  always_comb begin
    w_led_next = c_led_off;
    if (w_change) begin
      // Entry values are loaded at the same edge as the state change.
      case (w_next_state)
        S_BLINK: w_led_next = c_led_off;
        S_SOLID: w_led_next = c_led_on;
        S_CHASE: w_led_next = c_led_bit0;
        S_DIM:   w_led_next = c_led_on;
        default: w_led_next = c_led_off;
      endcase
    end else begin
      case (r_state)
        S_BLINK: begin
          w_led_next = w_wrap ? ~r_led : r_led;
        end
        S_SOLID: begin
          w_led_next = c_led_on;
        end
        S_CHASE: begin
          // Rotate left, MSB re-enters at bit 0.
          w_led_next = w_wrap ? {r_led[N_LED-2:0], r_led[N_LED-1]} : r_led;
        end
        S_DIM: begin
          // Lit on one cycle in four: whenever the phase rolls over to 0.
          w_led_next = (w_phase_inc == 2'd0) ? c_led_on : c_led_off;
        end
        default: begin
          w_led_next = c_led_off;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign LED   = r_led;
  assign STATE = r_state;
  assign TICK  = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_pattern_ctrl
//  Purpose  : Directed self-checking bench for led_pattern_ctrl. Two
//             instances: N_LED=4/DIV=4 for the main scenarios and
//             N_LED=8/DIV=2 for the parameter sweep.
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_pattern_ctrl;

  logic       CLK;
  logic       RST_N;
  logic       KEY;
  logic [1:0] SEL;
  logic [3:0] LED;
  logic [2:0] STATE;
  logic       TICK;

  logic       KEY8;
  logic [1:0] SEL8;
  logic [7:0] LED8;
  logic [2:0] STATE8;
  logic       TICK8;

  int errors;
  int checks;

  led_pattern_ctrl #(.N_LED(4), .DIV(4)) dut4 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .KEY   (KEY),
    .SEL   (SEL),
    .LED   (LED),
    .STATE (STATE),
    .TICK  (TICK)
  );

  led_pattern_ctrl #(.N_LED(8), .DIV(2)) dut8 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .KEY   (KEY8),
    .SEL   (SEL8),
    .LED   (LED8),
    .STATE (STATE8),
    .TICK  (TICK8)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST_N = 1'b0; KEY = 1'b0; SEL = 2'd0; KEY8 = 1'b0; SEL8 = 2'd0;
    cyc(2);
    checks++;
    if (LED !== 4'b0000 || STATE !== 3'd0 || TICK !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: LED=%b STATE=%0d TICK=%b, want 0000/0/0", LED, STATE, TICK);
    end
    checks++;
    if (LED8 !== 8'h00 || STATE8 !== 3'd0 || TICK8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state8: LED=%b STATE=%0d TICK=%b, want 0/0/0", LED8, STATE8, TICK8);
    end
    RST_N = 1'b1;
    cyc(2);
    checks++;
    if (STATE !== 3'd0 || LED !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_reset: STATE=%0d LED=%b, want 0/0000", STATE, LED);
    end
  endtask

  task automatic test_chase;
    logic [3:0] exp;
    SEL = 2'd2; KEY = 1'b1;
    cyc(1);
    KEY = 1'b0;
    checks++;
    if (STATE !== 3'd3 || LED !== 4'b0001) begin
      errors++;
      $display("FAIL chase_entry: STATE=%0d LED=%b, want 3/0001", STATE, LED);
    end
    for (int k = 1; k <= 16; k++) begin
      cyc(1);
      exp = 4'b0001 << ((k / 4) % 4);
      checks++;
      if ($countones(LED) != 1) begin
        errors++;
        $display("FAIL chase_onehot k=%0d: LED=%b, want exactly one bit", k, LED);
      end
      checks++;
      if (LED !== exp) begin
        errors++;
        $display("FAIL chase_led k=%0d: LED=%b, want %b", k, LED, exp);
      end
      checks++;
      if (TICK !== (k % 4 == 0)) begin
        errors++;
        $display("FAIL chase_tick k=%0d: TICK=%b, want %b", k, TICK, (k % 4 == 0));
      end
    end
  endtask

  task automatic test_reset_mid_chase;
    cyc(4);   // chase now shows 0010 with TICK high
    #2;
    RST_N = 1'b0; KEY = 1'b1; SEL = 2'd0;
    #1;
    checks++;
    if (LED !== 4'b0000 || STATE !== 3'd0 || TICK !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: LED=%b STATE=%0d TICK=%b, want 0000/0/0", LED, STATE, TICK);
    end
    cyc(1);
    checks++;
    if (STATE !== 3'd0 || LED !== 4'b0000) begin
      errors++;
      $display("FAIL key_during_reset: STATE=%0d LED=%b, want 0/0000", STATE, LED);
    end
    RST_N = 1'b1;
    cyc(1);
    // KEY already high at release: first clock counts as a press.
    checks++;
    if (STATE !== 3'd1 || LED !== 4'b0000) begin
      errors++;
      $display("FAIL key_high_at_release: STATE=%0d LED=%b, want 1/0000", STATE, LED);
    end
    KEY = 1'b0; cyc(1);
    KEY = 1'b1; cyc(1);
    KEY = 1'b0; cyc(1);
    checks++;
    if (STATE !== 3'd0) begin
      errors++;
      $display("FAIL stop_after_release: STATE=%0d, want 0", STATE);
    end
  endtask

  task automatic test_blink;
    SEL = 2'd0; KEY = 1'b1;
    cyc(1);
    KEY = 1'b0;
    checks++;
    if (STATE !== 3'd1 || LED !== 4'b0000) begin
      errors++;
      $display("FAIL blink_entry: STATE=%0d LED=%b, want 1/0000", STATE, LED);
    end
    cyc(3);
    checks++;
    if (LED !== 4'b0000 || TICK !== 1'b0) begin
      errors++;
      $display("FAIL blink_before_tick: LED=%b TICK=%b, want 0000/0", LED, TICK);
    end
    cyc(1);
    checks++;
    if (LED !== 4'b1111 || TICK !== 1'b1) begin
      errors++;
      $display("FAIL blink_on: LED=%b TICK=%b, want 1111/1", LED, TICK);
    end
    cyc(1);
    checks++;
    if (LED !== 4'b1111 || TICK !== 1'b0) begin
      errors++;
      $display("FAIL blink_tick_pulse: LED=%b TICK=%b, want 1111/0", LED, TICK);
    end
    cyc(3);
    checks++;
    if (LED !== 4'b0000 || TICK !== 1'b1) begin
      errors++;
      $display("FAIL blink_off: LED=%b TICK=%b, want 0000/1", LED, TICK);
    end
    KEY = 1'b1; cyc(1);
    KEY = 1'b0;
    checks++;
    if (STATE !== 3'd0 || LED !== 4'b0000) begin
      errors++;
      $display("FAIL blink_stop: STATE=%0d LED=%b, want 0/0000", STATE, LED);
    end
    cyc(1);
  endtask

  task automatic test_hold;
    SEL = 2'd1; KEY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      checks++;
      if (STATE !== 3'd2 || LED !== 4'b1111) begin
        errors++;
        $display("FAIL hold_key cycle=%0d: STATE=%0d LED=%b, want 2/1111", i, STATE, LED);
      end
    end
    KEY = 1'b0;
    cyc(1);
    KEY = 1'b1; cyc(1);
    KEY = 1'b0; cyc(1);
    checks++;
    if (STATE !== 3'd0) begin
      errors++;
      $display("FAIL hold_then_stop: STATE=%0d, want 0", STATE);
    end
  endtask

  task automatic test_live_switch;
    SEL = 2'd0; KEY = 1'b1;
    cyc(1);
    KEY = 1'b0;
    cyc(2);
    SEL = 2'd1;
    cyc(1);
    checks++;
    if (STATE !== 3'd2 || LED !== 4'b1111 || TICK !== 1'b0) begin
      errors++;
      $display("FAIL live_to_solid: STATE=%0d LED=%b TICK=%b, want 2/1111/0", STATE, LED, TICK);
    end
    // Prescaler must restart at the switch: no tick until 4 cycles later.
    cyc(1);
    checks++;
    if (TICK !== 1'b0) begin
      errors++;
      $display("FAIL live_prescaler_clear: TICK=%b, want 0", TICK);
    end
    cyc(2);
    checks++;
    if (TICK !== 1'b0) begin
      errors++;
      $display("FAIL live_no_early_tick: TICK=%b, want 0", TICK);
    end
    cyc(1);
    checks++;
    if (TICK !== 1'b1 || LED !== 4'b1111) begin
      errors++;
      $display("FAIL solid_tick: TICK=%b LED=%b, want 1/1111", TICK, LED);
    end
    SEL = 2'd3;
    cyc(1);
    checks++;
    if (STATE !== 3'd4 || LED !== 4'b1111) begin
      errors++;
      $display("FAIL live_to_dim: STATE=%0d LED=%b, want 4/1111", STATE, LED);
    end
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      checks++;
      if (LED !== ((k % 4 == 0) ? 4'b1111 : 4'b0000)) begin
        errors++;
        $display("FAIL dim_duty k=%0d: LED=%b, want %b", k, LED, ((k % 4 == 0) ? 4'b1111 : 4'b0000));
      end
    end
  endtask

  task automatic test_priority;
    KEY = 1'b1; cyc(1);
    KEY = 1'b0;
    checks++;
    if (STATE !== 3'd0 || LED !== 4'b0000) begin
      errors++;
      $display("FAIL dim_stop: STATE=%0d LED=%b, want 0/0000", STATE, LED);
    end
    cyc(1);
    SEL = 2'd2; KEY = 1'b1; cyc(1);
    KEY = 1'b0;
    checks++;
    if (STATE !== 3'd3) begin
      errors++;
      $display("FAIL prio_chase_start: STATE=%0d, want 3", STATE);
    end
    cyc(2);
    KEY = 1'b1; SEL = 2'd0;
    cyc(1);
    KEY = 1'b0;
    checks++;
    if (STATE !== 3'd0 || LED !== 4'b0000) begin
      errors++;
      $display("FAIL press_priority: STATE=%0d LED=%b, want 0/0000", STATE, LED);
    end
    cyc(3);
    checks++;
    if (STATE !== 3'd0 || LED !== 4'b0000) begin
      errors++;
      $display("FAIL idle_holds: STATE=%0d LED=%b, want 0/0000", STATE, LED);
    end
    SEL = 2'd1; KEY = 1'b1;
    cyc(1);
    KEY = 1'b0;
    checks++;
    if (STATE !== 3'd2 || LED !== 4'b1111) begin
      errors++;
      $display("FAIL second_press_solid: STATE=%0d LED=%b, want 2/1111", STATE, LED);
    end
  endtask

  task automatic test_sweep;
    logic [7:0] exp8;
    SEL8 = 2'd2; KEY8 = 1'b1;
    cyc(1);
    KEY8 = 1'b0;
    checks++;
    if (STATE8 !== 3'd3 || LED8 !== 8'b0000_0001) begin
      errors++;
      $display("FAIL sweep_entry: STATE=%0d LED=%b, want 3/00000001", STATE8, LED8);
    end
    for (int k = 1; k <= 16; k++) begin
      cyc(1);
      exp8 = 8'b0000_0001 << ((k / 2) % 8);
      checks++;
      if ($countones(LED8) != 1) begin
        errors++;
        $display("FAIL sweep_onehot k=%0d: LED=%b, want exactly one bit", k, LED8);
      end
      checks++;
      if (LED8 !== exp8) begin
        errors++;
        $display("FAIL sweep_led k=%0d: LED=%b, want %b", k, LED8, exp8);
      end
      checks++;
      if (TICK8 !== (k % 2 == 0)) begin
        errors++;
        $display("FAIL sweep_tick k=%0d: TICK=%b, want %b", k, TICK8, (k % 2 == 0));
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset;
    test_chase;
    test_reset_mid_chase;
    test_blink;
    test_hold;
    test_live_switch;
    test_priority;
    test_sweep;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
